// File: rtl/cim_bitserial_mac_engine_if.sv
// Purpose : request/response bundle between the SRAM front end, the bit-serial CIM MAC engine and the output collector.
// Latency : none (wires only).
// Backpressure: request side via in_valid/in_ready, result side via out_valid/out_ready.
// Ports   : master = front end + collector (drives requests, out_ready); slave = engine.
interface cim_bitserial_mac_engine_if #(
  parameter int NUM_CHANNELS = 8,
  parameter int NUM_INPUTS   = 8,
  parameter int ACT_W        = 8,
  parameter int MAX_WT_BITS  = 8,
  parameter int SCALE_W      = 4,
  parameter int OUT_W        = ACT_W + $clog2(NUM_INPUTS) + MAX_WT_BITS + SCALE_W + 1,
  parameter int CFG_W        = $clog2(MAX_WT_BITS + 1)
);
  logic                                               in_valid;
  logic                                               in_ready;
  logic [NUM_CHANNELS-1:0][NUM_INPUTS-1:0][ACT_W-1:0]       act;
  logic [NUM_CHANNELS-1:0][NUM_INPUTS-1:0][MAX_WT_BITS-1:0] wt;
  logic [NUM_CHANNELS-1:0][SCALE_W-1:0]               scale;
  logic [NUM_CHANNELS-1:0]                            ch_en;
  logic [CFG_W-1:0]                                   cfg_wt_bits;
  logic                                               cfg_signed;
  logic                                               abort;
  logic                                               out_valid;
  logic                                               out_ready;
  logic [NUM_CHANNELS-1:0][OUT_W-1:0]                 out_data;
  logic                                               busy;
  logic [15:0]                                        done_cnt;

  modport master (
    output in_valid, act, wt, scale, ch_en, cfg_wt_bits, cfg_signed, abort, out_ready,
    input  in_ready, out_valid, out_data, busy, done_cnt
  );

  modport slave (
    input  in_valid, act, wt, scale, ch_en, cfg_wt_bits, cfg_signed, abort, out_ready,
    output in_ready, out_valid, out_data, busy, done_cnt
  );
endinterface

// File: rtl/cim_bitserial_mac_engine.sv
// Purpose : multi-channel bit-serial CIM MAC; MSB-first shift-accumulate of weight bit-planes, then per-channel scale.
// Latency : result visible eb+1 cycles after the accept edge; one op in flight (period eb+2 with out_ready=1).
// Backpressure: in_ready only in IDLE; result held stable in OUT until out_ready.
// Ports   : i_clk, i_reset (async, active-high), io_bus (slave modport: request, abort, result, busy, done_cnt).
module cim_bitserial_mac_engine #(
  parameter int NUM_CHANNELS = 8,
  parameter int NUM_INPUTS   = 8,
  parameter int ACT_W        = 8,
  parameter int MAX_WT_BITS  = 8,
  parameter int SCALE_W      = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  cim_bitserial_mac_engine_if.slave io_bus
);
  localparam int PSUM_W = ACT_W + $clog2(NUM_INPUTS);
  localparam int ACC_W  = PSUM_W + MAX_WT_BITS;
  localparam int OUT_W  = ACC_W + SCALE_W + 1;
  localparam int CFG_W  = $clog2(MAX_WT_BITS + 1);
  localparam int K_W    = (MAX_WT_BITS > 1) ? $clog2(MAX_WT_BITS) : 1;
  localparam logic [CFG_W-1:0] MAX_EB = CFG_W'(MAX_WT_BITS);

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_SCALE, S_OUT} state_t;

  state_t r_state, w_state_nxt;

  logic [NUM_CHANNELS-1:0][NUM_INPUTS-1:0][ACT_W-1:0]       r_act;
  logic [NUM_CHANNELS-1:0][NUM_INPUTS-1:0][MAX_WT_BITS-1:0] r_wt;
  logic [NUM_CHANNELS-1:0][SCALE_W-1:0]                     r_scale;
  logic [NUM_CHANNELS-1:0]                                  r_ch_en;
  logic                                                     r_signed;
  logic [CFG_W-1:0]                                         r_eb;
  logic [K_W-1:0]                                           r_k;
  logic signed [ACC_W-1:0]                                  r_acc [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0][OUT_W-1:0]                       r_out_data;
  logic [15:0]                                              r_done_cnt;

  logic [CFG_W-1:0]         w_eb;
  logic                     w_first;
  logic                     w_neg_first;
  logic signed [PSUM_W-1:0] w_psum    [NUM_CHANNELS];
  logic signed [ACC_W-1:0]  w_acc_nxt [NUM_CHANNELS];
  logic signed [OUT_W-1:0]  w_prod    [NUM_CHANNELS];

  // Out-of-range precision (0 or above the maximum) falls back to full precision.
  always_comb begin
    w_eb = io_bus.cfg_wt_bits;
    if (io_bus.cfg_wt_bits == '0 || io_bus.cfg_wt_bits > MAX_EB) w_eb = MAX_EB;
  end

  // The MSB plane of a signed weight carries negative weight; a 1-bit signed weight is treated as 0/1.
  assign w_first     = (r_k == K_W'(r_eb - CFG_W'(1)));
  assign w_neg_first = r_signed && (r_eb > CFG_W'(1)) && w_first;

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      w_psum[c] = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (r_wt[c][i][r_k]) w_psum[c] = w_psum[c] + PSUM_W'($signed(r_act[c][i]));
      end
      if (w_first) w_acc_nxt[c] = w_neg_first ? -ACC_W'(w_psum[c]) : ACC_W'(w_psum[c]);
      else         w_acc_nxt[c] = (r_acc[c] <<< 1) + ACC_W'(w_psum[c]);
      w_prod[c] = OUT_W'(r_acc[c]) * OUT_W'($signed({1'b0, r_scale[c]}));
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (io_bus.in_valid) w_state_nxt = S_COMPUTE;
      S_COMPUTE: begin
        if (io_bus.abort)      w_state_nxt = S_IDLE;
        else if (r_k == '0)    w_state_nxt = S_SCALE;
      end
      S_SCALE:   w_state_nxt = io_bus.abort ? S_IDLE : S_OUT;
      S_OUT:     if (io_bus.out_ready) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_act      <= '0;
      r_wt       <= '0;
      r_scale    <= '0;
      r_ch_en    <= '0;
      r_signed   <= 1'b0;
      r_eb       <= '0;
      r_k        <= '0;
      r_out_data <= '0;
      r_done_cnt <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) r_acc[c] <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (io_bus.in_valid) begin
          r_act    <= io_bus.act;
          r_wt     <= io_bus.wt;
          r_scale  <= io_bus.scale;
          r_ch_en  <= io_bus.ch_en;
          r_signed <= io_bus.cfg_signed;
          r_eb     <= w_eb;
          r_k      <= K_W'(w_eb - CFG_W'(1));
        end
        S_COMPUTE: if (!io_bus.abort) begin
          for (int c = 0; c < NUM_CHANNELS; c++) r_acc[c] <= w_acc_nxt[c];
          if (r_k != '0) r_k <= r_k - K_W'(1);
        end
        // An aborted op leaves the previous result on out_data.
        S_SCALE: if (!io_bus.abort) begin
          for (int c = 0; c < NUM_CHANNELS; c++) r_out_data[c] <= r_ch_en[c] ? w_prod[c] : '0;
        end
        S_OUT: if (io_bus.out_ready) r_done_cnt <= r_done_cnt + 16'd1;
        default: ;
      endcase
    end
  end

  assign io_bus.in_ready  = (r_state == S_IDLE);
  assign io_bus.out_valid = (r_state == S_OUT);
  assign io_bus.busy      = (r_state != S_IDLE);
  assign io_bus.out_data  = r_out_data;
  assign io_bus.done_cnt  = r_done_cnt;
endmodule

// File: tb/tb_cim_bitserial_mac_engine.sv
// Purpose : self-checking bench for cim_bitserial_mac_engine with a dot-product reference model and result scoreboard.
// Latency : checks result latency of eb+1 cycles after accept.
// Backpressure: exercises held out_ready, random out_ready, abort, mid-op reset and counter wrap.
module tb_cim_bitserial_mac_engine;
  localparam int NC     = 2;
  localparam int NI     = 4;
  localparam int AW     = 8;
  localparam int MWB    = 4;
  localparam int SW     = 4;
  localparam int PSUM_W = AW + $clog2(NI);
  localparam int ACC_W  = PSUM_W + MWB;
  localparam int OUT_W  = ACC_W + SW + 1;
  localparam int CFG_W  = $clog2(MWB + 1);

  typedef logic [NC-1:0][NI-1:0][AW-1:0]  act_t;
  typedef logic [NC-1:0][NI-1:0][MWB-1:0] wt_t;
  typedef logic [NC-1:0][SW-1:0]          scale_t;
  typedef logic [NC-1:0][OUT_W-1:0]       out_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cim_bitserial_mac_engine_if #(
    .NUM_CHANNELS(NC), .NUM_INPUTS(NI), .ACT_W(AW), .MAX_WT_BITS(MWB), .SCALE_W(SW),
    .OUT_W(OUT_W), .CFG_W(CFG_W)
  ) bus ();

  cim_bitserial_mac_engine #(
    .NUM_CHANNELS(NC), .NUM_INPUTS(NI), .ACT_W(AW), .MAX_WT_BITS(MWB), .SCALE_W(SW)
  ) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .io_bus (bus)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_done = 0;
  out_t sb_q[$];

  task automatic check(input string name, input longint got, input longint want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference model: plain integer dot product of activations with decoded weights, times scale.
  function automatic int eff_bits(input int cfg);
    return (cfg >= 1 && cfg <= MWB) ? cfg : MWB;
  endfunction

  function automatic longint model_ch(input act_t a, input wt_t w, input scale_t s,
                                      input logic [NC-1:0] en, input int cfg, input bit sgn, input int c);
    int     eb;
    longint sum;
    int     wv;
    eb  = eff_bits(cfg);
    sum = 0;
    for (int i = 0; i < NI; i++) begin
      wv = int'(w[c][i]) & ((1 << eb) - 1);
      if (sgn && eb > 1 && wv >= (1 << (eb - 1))) wv = wv - (1 << eb);
      sum += longint'($signed(a[c][i])) * wv;
    end
    return en[c] ? sum * longint'(s[c]) : 0;
  endfunction

  function automatic out_t model(input act_t a, input wt_t w, input scale_t s,
                                 input logic [NC-1:0] en, input int cfg, input bit sgn);
    out_t r;
    for (int c = 0; c < NC; c++) r[c] = OUT_W'(model_ch(a, w, s, en, cfg, sgn, c));
    return r;
  endfunction

  // Monitor: every accepted result is compared against the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got a result, expected none (t=%0t)", $time);
      end else begin
        out_t e;
        e = sb_q.pop_front();
        for (int c = 0; c < NC; c++)
          check($sformatf("out_data[%0d]", c), longint'($signed(bus.out_data[c])), longint'($signed(e[c])));
      end
    end
  end

  // All tasks are entered and left #1 after a rising edge.
  task automatic issue_op(input act_t a, input wt_t w, input scale_t s, input logic [NC-1:0] en,
                          input int cfg, input bit sgn, input bit push);
    int t;
    t = 0;
    while (!bus.in_ready && t < 100) begin @(posedge clk); #1; t++; end
    if (!bus.in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: in_ready=0, expected 1");
    end
    bus.act         = a;
    bus.wt          = w;
    bus.scale       = s;
    bus.ch_en       = en;
    bus.cfg_wt_bits = CFG_W'(cfg);
    bus.cfg_signed  = sgn;
    bus.in_valid    = 1'b1;
    if (push) sb_q.push_back(model(a, w, s, en, cfg, sgn));
    @(posedge clk); #1;
    bus.in_valid    = 1'b0;
  endtask

  task automatic wait_result(input int cfg);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
    check("latency", lat, eff_bits(cfg) + 1);
  endtask

  task automatic finish_op(input bit rnd);
    int t;
    t = 0;
    bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while (!(bus.out_valid && bus.out_ready) && t < 200) begin
      @(posedge clk); #1; t++;
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (t >= 200) begin
      n_cmp++; n_err++;
      $display("FAIL handshake_timeout: out_valid=%0d, expected 1", bus.out_valid);
    end
    @(posedge clk); #1;
    exp_done      = (exp_done + 1) & 16'hFFFF;
    bus.out_ready = 1'b1;
    check("done_cnt", bus.done_cnt, exp_done);
    check("out_valid_drop", bus.out_valid, 0);
  endtask

  task automatic run_op(input act_t a, input wt_t w, input scale_t s, input logic [NC-1:0] en,
                        input int cfg, input bit sgn, input bit rnd);
    issue_op(a, w, s, en, cfg, sgn, 1'b1);
    wait_result(cfg);
    finish_op(rnd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    act_t   a, a2;
    wt_t    w;
    scale_t s;
    out_t   snap;
    bus.in_valid = 0; bus.act = '0; bus.wt = '0; bus.scale = '0; bus.ch_en = '0;
    bus.cfg_wt_bits = '0; bus.cfg_signed = 0; bus.abort = 0; bus.out_ready = 1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done_cnt", bus.done_cnt, 0);
    check("rst_out_data", longint'(bus.out_data), 0);
    reset = 0;
    @(posedge clk); #1;

    // Unsigned 4-bit weights, scale 1.
    for (int c = 0; c < NC; c++) begin
      a[c] = {8'd4, 8'd3, 8'd2, 8'd1};
      w[c] = {4'd15, 4'd5, 4'd0, 4'd3};
      s[c] = 4'd1;
    end
    run_op(a, w, s, 2'b11, 4, 1'b0, 1'b0);

    // Signed all-ones weights (-1), then precision 0 falling back to full width.
    for (int c = 0; c < NC; c++) begin w[c] = {4'hF, 4'hF, 4'hF, 4'hF}; s[c] = 4'd2; end
    run_op(a, w, s, 2'b11, 4, 1'b1, 1'b0);
    run_op(a, w, s, 2'b11, 0, 1'b1, 1'b0);

    // Extremes: most negative activation times most negative weight, max scale; then channel mask.
    for (int c = 0; c < NC; c++) begin
      a[c] = {8'h80, 8'h80, 8'h80, 8'h80};
      w[c] = {4'h8, 4'h8, 4'h8, 4'h8};
      s[c] = 4'd15;
    end
    run_op(a, w, s, 2'b11, 4, 1'b1, 1'b0);
    run_op(a, w, s, 2'b01, 4, 1'b1, 1'b0);

    // Single-bit signed weight acts as 0/1.
    run_op(a, w, s, 2'b11, 1, 1'b1, 1'b0);

    // Held backpressure in OUT with a competing request.
    for (int c = 0; c < NC; c++) begin
      a[c] = {8'd7, 8'hF9, 8'd20, 8'hE0};
      w[c] = {4'd9, 4'd6, 4'd3, 4'd12};
      s[c] = 4'd5;
    end
    bus.out_ready = 1'b0;
    issue_op(a, w, s, 2'b11, 4, 1'b1, 1'b1);
    wait_result(4);
    snap = bus.out_data;
    a2   = {$urandom(), $urandom()};
    bus.act = a2; bus.in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_data_stable", (bus.out_data == snap) ? 1 : 0, 1);
      check("bp_done_cnt", bus.done_cnt, exp_done);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    exp_done = (exp_done + 1) & 16'hFFFF;
    check("bp_done_once", bus.done_cnt, exp_done);
    check("bp_idle", bus.busy, 0);
    @(posedge clk); #1;
    check("bp_no_accept", bus.busy, 0);
    check("bp_done_hold", bus.done_cnt, exp_done);

    // Abort in the second COMPUTE cycle.
    snap = bus.out_data;
    for (int c = 0; c < NC; c++) begin w[c] = {4'd1, 4'd2, 4'd3, 4'd4}; s[c] = 4'd3; end
    issue_op(a, w, s, 2'b11, 4, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_in_ready", bus.in_ready, 1);
    for (int k = 0; k < 6; k++) begin
      check("abort_no_valid", bus.out_valid, 0);
      @(posedge clk); #1;
    end
    check("abort_done_cnt", bus.done_cnt, exp_done);
    check("abort_out_data_kept", (bus.out_data == snap) ? 1 : 0, 1);

    // Abort while the result is waiting in OUT is ignored.
    bus.out_ready = 1'b0;
    issue_op(a, w, s, 2'b10, 3, 1'b0, 1'b1);
    wait_result(3);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("abort_in_out_ignored", bus.out_valid, 1);
    finish_op(1'b0);

    // Random operations with random output backpressure.
    for (int n = 0; n < 30; n++) begin
      a = {$urandom(), $urandom()};
      w = $urandom();
      s = 8'($urandom());
      run_op(a, w, s, 2'($urandom()), int'($urandom_range(0, 7)), 1'($urandom()), 1'b1);
    end

    // Reset mid-COMPUTE.
    issue_op(a, w, s, 2'b11, 4, 1'b1, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rst_mid_out_data", longint'(bus.out_data), 0);
    check("rst_mid_done_cnt", bus.done_cnt, 0);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_out_valid", bus.out_valid, 0);
    exp_done = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_release_in_ready", bus.in_ready, 1);

    // Counter wrap from 0xFFFF.
    force dut.r_done_cnt = 16'hFFFF;
    @(posedge clk); #1;
    release dut.r_done_cnt;
    @(posedge clk); #1;
    exp_done = 16'hFFFF;
    check("wrap_preload", bus.done_cnt, exp_done);
    run_op(a, w, s, 2'b11, 2, 1'b1, 1'b0);
    check("wrap_zero", bus.done_cnt, 0);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cim_bitserial_mac_engine.md
Name: cim_bitserial_mac_engine

Overview:
- Parametrised successor to the current CIM datapath: multi-channel bit-serial compute-in-memory MAC.
- Each channel multiplies a vector of signed activations by a weight vector whose precision is set per operation (1..MAX_WT_BITS). Weights can be signed or unsigned.
- Each channel shift-accumulates MSB-first, then multiplies by a per-channel unsigned scale.
- Sits between the activation/weight SRAM front end and the output collector. Both ends use valid/ready handshakes.

Parameters:
- NUM_CHANNELS, 8, number of independent stacks/channels.
- NUM_INPUTS, 8, activations per channel (power of 2, >=2).
- ACT_W, 8, signed activation width.
- MAX_WT_BITS, 8, maximum weight precision.
- SCALE_W, 4, unsigned per-channel scale width.
- PSUM_W, ACT_W+$clog2(NUM_INPUTS), per-bit partial-sum width (signed).
- ACC_W, PSUM_W+MAX_WT_BITS, accumulator width (signed).
- OUT_W, ACC_W+SCALE_W+1, output width (signed).

Ports:
- clk  in  1  clock.
- reset  in  1  async active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  engine can accept.
- act  in  [NUM_CHANNELS][NUM_INPUTS][ACT_W]  signed activations.
- wt  in  [NUM_CHANNELS][NUM_INPUTS][MAX_WT_BITS]  weights; bits [cfg-1:0] used.
- scale  in  [NUM_CHANNELS][SCALE_W]  unsigned scale.
- ch_en  in  NUM_CHANNELS  channel enable mask.
- cfg_wt_bits  in  $clog2(MAX_WT_BITS+1)  weight precision.
- cfg_signed  in  1  1 = two's-complement weights.
- abort  in  1  synchronous abort of the op in flight.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_data  out  [NUM_CHANNELS][OUT_W]  signed scaled results.
- busy  out  1  state != IDLE.
- done_cnt  out  16  completed-transaction counter.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high (reset).
  - On reset: state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0, done_cnt=0, all internal registers 0.
- FSM states: IDLE, COMPUTE, SCALE, OUT.
- IDLE: in_ready=1. On in_valid, capture act, wt, scale, ch_en, cfg_signed and effective bits eb. Then go to COMPUTE with bit index k=eb-1.
  - eb = cfg_wt_bits if 1..MAX_WT_BITS.
  - eb = MAX_WT_BITS for 0 or any larger value.
- COMPUTE, one bit per cycle, MSB-first:
  - psum = sum of act[i] over all i where wt[i][k]=1 (sign-extended to PSUM_W).
  - First cycle (k=eb-1): acc = (cfg_signed && eb>1) ? -psum : psum.
  - Later cycles: acc = (acc<<<1) + psum.
  - Leave COMPUTE after the k=0 cycle. COMPUTE lasts exactly eb cycles.
  - With eb=1 and signed, the single bit is treated as unsigned (value 0/1).
- SCALE, one cycle: out_data[c] = ch_en[c] ? acc[c]*$signed({1'b0,scale[c]}) : 0. Then go to OUT.
- OUT: out_valid=1; out_data held stable until out_valid && out_ready.
  - On that handshake: done_cnt += 1 (wraps 0xFFFF->0), go to IDLE, out_valid drops the next cycle.
- Latency: the result is visible eb+1 cycles after the accept edge. Minimum op period is eb+2 cycles with out_ready=1.
- in_ready=0 in every state except IDLE. in_valid outside IDLE is ignored (no queueing).
- abort, sampled in COMPUTE or SCALE: go to IDLE next cycle. out_valid is never raised, done_cnt is unchanged, and out_data keeps its previous value.
  - abort in OUT or IDLE has no effect.
- reset mid-operation: immediate return to reset values; the operation is lost.
- Arithmetic: all signed. No overflow is possible given the widths above. Disabled channels still compute internally, but their outputs are forced to 0.
- ch_en, cfg and scale are captured once at accept. Changes while busy do not affect the operation in flight.

Test Plan:
- Params NUM_CHANNELS=2, NUM_INPUTS=4, ACT_W=8, MAX_WT_BITS=4, SCALE_W=4 for all scenarios.
- Unsigned: act=[1,2,3,4], wt=[3,0,5,15], cfg_wt_bits=4, cfg_signed=0, scale=1 -> out_data=78 on both channels; out_valid rises 5 cycles after accept.
- Signed: wt all 4'b1111, act=[1,2,3,4], cfg_signed=1, scale=2 -> out_data=-20. Then cfg_wt_bits=0 with the same inputs -> eb=4, same result.
- Extremes: act all -128, wt all 4'b1000 signed, scale=15 -> out_data=61440. With ch_en=2'b01 -> channel1=0, channel0=61440.
- Backpressure: hold out_ready=0 for 3 cycles in OUT -> out_data stable, in_ready=0, a concurrent in_valid is not accepted. done_cnt increments once, on the ready cycle.
- Abort/reset: abort on the 2nd COMPUTE cycle -> IDLE next cycle, no out_valid, done_cnt unchanged. Reset asserted mid-COMPUTE -> all outputs 0 asynchronously, in_ready=1 after release.
- Counter wrap: preload 0xFFFF completions (force) and complete one more op -> done_cnt=0.
